seg7_scan_ctrl: RTL and testbench

- Parametrised multiplexed seven-segment scan controller for the board top; replaces the fixed 8-digit o_seg/o_sel driver.
- Takes a packed hex word plus decimal-point mask from the CPU I/O side and time-multiplexes it onto DIGITS common-anode digits.
- Double-buffered: new data is committed only at a frame boundary, so the display never tears.

---
 rtl/seg7_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment scan controller with frame-synchronous double buffering (optional macro SEG7_LZ_BLANK_EN enables leading-zero blanking)
module seg7_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV = 50000
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [7:0]            o_seg,
    output logic [DIGITS-1:0]     o_sel,
    output logic                  frame_done
);
    localparam int PW = $clog2(DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] pend_data, disp_data;
    logic [DIGITS-1:0]   pend_dp, disp_dp, blank;
    logic                tick, wrap;
    logic [3:0]          nib;
    logic [6:0]          glyph;

    assign tick = enable && pcnt == PW'(DIV - 1);
    assign wrap = tick && idx == IW'(DIGITS - 1);
    assign nib  = disp_data[{idx, 2'b00} +: 4];

    // prescaler and digit index; both freeze while enable is low
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= wrap ? '0 : idx + IW'(1);
        end else if (enable) begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // pending buffer takes every load; display is refreshed only at frame wrap, bypassing a same-cycle load
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp_mask;
            end
            if (wrap) begin
                disp_data <= load ? data : pend_data;
                disp_dp   <= load ? dp_mask : pend_dp;
            end
        end
    end

    // hex nibble to active-low g..a segment pattern
    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    end

    // blank mask: a digit is blanked when it and every more-significant nibble is zero (digit 0 never)
    always_comb begin
        blank = '0;
`ifdef SEG7_LZ_BLANK_EN
        begin
            logic z;
            z = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                z = z && disp_data[4*i +: 4] == 4'h0;
                blank[i] = z;
            end
        end
`endif
    end

    // registered drive of segments, select and frame pulse
    always_ff @(posedge clk_in) begin
        if (reset) begin
            o_seg      <= 8'hFF;
            o_sel      <= '1;
            frame_done <= 1'b0;
        end else begin
            o_seg      <= enable ? {~disp_dp[idx], blank[idx] ? 7'h7F : glyph} : 8'hFF;
            o_sel      <= enable ? ~(DIGITS'(1) << idx) : '1;
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl (DIGITS=8, DIV=4)
module tb_seg7_scan_ctrl;
    localparam int DIGITS = 8;
    localparam int DIV = 4;
    localparam int LAST = DIGITS * DIV - 1;

    logic        clk = 0, reset = 1, enable = 0, load = 0;
    logic [31:0] data = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  o_seg, o_sel;
    logic        frame_done;

    int vectors = 0, miscompares = 0;

    // reference model: position within the frame as one counter, buffers as plain words
    int          phase = 0;
    logic [31:0] pend_w = '0, disp_w = '0;
    logic [7:0]  pend_dp = '0, disp_dp = '0;
    logic [16:0] sb[$];
    logic [7:0]  glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk_in(clk), .reset(reset), .enable(enable), .load(load),
        .data(data), .dp_mask(dp_mask),
        .o_seg(o_seg), .o_sel(o_sel), .frame_done(frame_done)
    );

    function automatic logic [7:0] seg_of(int i);
        logic [31:0] w;
        logic [6:0]  g;
        w = disp_w >> (4 * i);
        g = glyph_tab[w[3:0]][6:0];
`ifdef SEG7_LZ_BLANK_EN
        if (i > 0 && w == 0) g = 7'h7F;
`endif
        return {~disp_dp[i], g};
    endfunction

    task automatic step();
        logic [7:0] s, sel;
        logic       fd;
        int         d;
        @(posedge clk);
        if (reset) begin
            phase = 0; pend_w = '0; disp_w = '0; pend_dp = '0; disp_dp = '0;
            s = 8'hFF; sel = 8'hFF; fd = 1'b0;
        end else begin
            d   = phase / DIV;
            s   = enable ? seg_of(d) : 8'hFF;
            sel = enable ? ~(8'd1 << d) : 8'hFF;
            fd  = enable && phase == LAST;
            if (load) begin pend_w = data; pend_dp = dp_mask; end
            if (enable) begin
                if (phase == LAST) begin
                    phase = 0; disp_w = pend_w; disp_dp = pend_dp;
                end else phase++;
            end
        end
        sb.push_back({s, sel, fd});
        #1;
    endtask

    task automatic wait_phase(int target);
        for (int k = 0; k < 4 * LAST && phase != target; k++) step();
        if (phase != target) begin
            vectors++; miscompares++;
            $display("FAIL wait_phase: phase %0d, required %0d", phase, target);
        end
    endtask

    // monitor: compare every presented output cycle against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [16:0] e;
            e = sb.pop_front();
            vectors++;
            if ({o_seg, o_sel, frame_done} !== e) begin
                miscompares++;
                $display("FAIL scan @%0t: seg/sel/fd got %h/%h/%b required %h/%h/%b",
                         $time, o_seg, o_sel, frame_done, e[16:9], e[8:1], e[0]);
            end
        end
    end

    initial begin
        repeat (3) step();
        reset = 0; enable = 1;
        repeat (40) step();
        load = 1; data = 32'h89ABCDEF; dp_mask = 8'h01; step(); load = 0;
        repeat (70) step();
        wait_phase(LAST);
        load = 1; data = 32'h12345678; dp_mask = 8'h00; step(); load = 0;
        repeat (10) step();
        wait_phase(3 * DIV + 1);
        enable = 0; repeat (10) step(); enable = 1;
        repeat (40) step();
        load = 1; data = 32'h00000405; dp_mask = 8'h00; step(); load = 0;
        repeat (70) step();
        wait_phase(5 * DIV + 2);
        reset = 1; step(); reset = 0;
        repeat (40) step();
        for (int n = 0; n < 800; n++) begin
            reset   = $urandom_range(0, 99) == 0;
            enable  = $urandom_range(0, 9) != 0;
            load    = $urandom_range(0, 7) == 0;
            data    = $urandom >> ($urandom_range(0, 7) * 4);
            dp_mask = 8'($urandom);
            step();
        end
        reset = 0; enable = 1; load = 0;
        repeat (5) step();
        @(negedge clk); #1;
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain: %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
